sevenseg_scan_decoder: RTL

Receive-side counterpart of the board's multiplexed seven-segment driver: samples the scanned `anode`/`cathode` lines and reconstructs the four displayed hex digits as a 16-bit word. It sits on the board-level display bus, either in loopback for self-check or in a second FPGA observing the display. It debounces scan transitions, decodes segment patterns back to nibbles, and reports a complete frame once every digit has been seen.

---
 rtl/sevenseg_pkg.sv | 90 +++++++++
 rtl/sevenseg_input_sync.sv | 29 ++
 rtl/sevenseg_scan_decoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment glyph definitions (segment bit 0 = a ... bit 6 = g, 1 = lit)
// used by both the scan decoder and the display driver.
package sevenseg_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_C     = 7'h39;
    localparam logic [6:0] GLYPH_D     = 7'h5E;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_F     = 7'h71;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    localparam int         SCAN_W  = 12;
    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } seg_decode_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } frame_state_t;

    function automatic seg_decode_t seg_to_nibble(input logic [6:0] seg);
        seg_decode_t r;
        r.legal  = 1'b1;
        r.blank  = 1'b0;
        r.nibble = 4'h0;
        case (seg)
            GLYPH_0:     r.nibble = 4'h0;
            GLYPH_1:     r.nibble = 4'h1;
            GLYPH_2:     r.nibble = 4'h2;
            GLYPH_3:     r.nibble = 4'h3;
            GLYPH_4:     r.nibble = 4'h4;
            GLYPH_5:     r.nibble = 4'h5;
            GLYPH_6:     r.nibble = 4'h6;
            GLYPH_7:     r.nibble = 4'h7;
            GLYPH_8:     r.nibble = 4'h8;
            GLYPH_9:     r.nibble = 4'h9;
            GLYPH_A:     r.nibble = 4'hA;
            GLYPH_B:     r.nibble = 4'hB;
            GLYPH_C:     r.nibble = 4'hC;
            GLYPH_D:     r.nibble = 4'hD;
            GLYPH_E:     r.nibble = 4'hE;
            GLYPH_F:     r.nibble = 4'hF;
            GLYPH_BLANK: r.blank  = 1'b1;
            default:     r.legal  = 1'b0;
        endcase
        return r;
    endfunction

    // Driver-side inverse so both ends of the display bus share one glyph table.
    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = GLYPH_0;
            4'h1:    s = GLYPH_1;
            4'h2:    s = GLYPH_2;
            4'h3:    s = GLYPH_3;
            4'h4:    s = GLYPH_4;
            4'h5:    s = GLYPH_5;
            4'h6:    s = GLYPH_6;
            4'h7:    s = GLYPH_7;
            4'h8:    s = GLYPH_8;
            4'h9:    s = GLYPH_9;
            4'hA:    s = GLYPH_A;
            4'hB:    s = GLYPH_B;
            4'hC:    s = GLYPH_C;
            4'hD:    s = GLYPH_D;
            4'hE:    s = GLYPH_E;
            4'hF:    s = GLYPH_F;
            default: s = GLYPH_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_input_sync.sv
// Two-flop synchronizer of configurable width; resets to a caller-chosen
// value so the downstream logic sees an idle bus while in reset.
module sevenseg_input_sync #(
    parameter int               WIDTH     = 12,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Synchronizer flop chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= data_i;
            sync_q <= meta_q;
        end
    end

    assign data_o = sync_q;

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Observes a multiplexed seven-segment scan bus and rebuilds the four displayed
// hex digits, publishing a frame once every digit position has been captured.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  anode,
    input  logic [7:0]  cathode,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        valid,
    output logic        illegal,
    output logic        stale
);

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [23:0] TMO_LIMIT   = 24'(TIMEOUT_CYCLES);
    localparam logic [23:0] TMO_MAX     = 24'hFFFFFF;

    logic [SCAN_W-1:0] sample_s;
    logic [SCAN_W-1:0] prev_q;
    logic [7:0]        cnt_q, cnt_d;
    logic [23:0]       tmo_q, tmo_d;
    logic              capture_pt_s, capture_s, one_hot_s, multi_s;
    logic [1:0]        idx_s;
    logic [3:0]        seen_next_s;
    seg_decode_t       dec_s;

    frame_state_t      state_q, state_d;
    logic [3:0]        seen_q, seen_d;
    logic [15:0]       sh_val_q, sh_val_d;
    logic [3:0]        sh_dp_q, sh_dp_d;
    logic [3:0]        sh_blank_q, sh_blank_d;
    logic [15:0]       value_q, value_d;
    logic [3:0]        dp_q, dp_d;
    logic [3:0]        blank_q, blank_d;
    logic              valid_q, valid_d;
    logic              illegal_q, illegal_d;
    logic              stale_q, stale_d;

    sevenseg_input_sync #(
        .WIDTH     (SCAN_W),
        .RESET_VAL ({SCAN_W{1'b1}})
    ) u_sync (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .data_i ({anode, cathode}),
        .data_o (sample_s)
    );

    // Dwell length of the current synchronized sample, saturating.
    always_comb begin
        if (sample_s == prev_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = 8'd0;
        end
    end

    // Exactly one capture point per dwell since the counter passes this value once.
    assign capture_pt_s = (cnt_d == SETTLE_LAST);

    // Anode classification: which digit is selected and whether the bus is ambiguous.
    always_comb begin
        idx_s     = 2'd0;
        one_hot_s = 1'b0;
        multi_s   = 1'b0;
        case (sample_s[11:8])
            4'b1110: begin idx_s = 2'd0; one_hot_s = 1'b1; end
            4'b1101: begin idx_s = 2'd1; one_hot_s = 1'b1; end
            4'b1011: begin idx_s = 2'd2; one_hot_s = 1'b1; end
            4'b0111: begin idx_s = 2'd3; one_hot_s = 1'b1; end
            4'b1111: begin idx_s = 2'd0; one_hot_s = 1'b0; end
            default: begin idx_s = 2'd0; multi_s   = 1'b1; end
        endcase
    end

    assign capture_s   = capture_pt_s & one_hot_s;
    assign dec_s       = seg_to_nibble(~sample_s[6:0]);
    assign seen_next_s = seen_q | (4'b0001 << idx_s);
    assign illegal_d   = illegal_q | (capture_s & ~dec_s.legal) | (capture_pt_s & multi_s);

    // Cycles since the last capture; a capture always wins over an expiring timeout.
    always_comb begin
        if (capture_s) begin
            tmo_d = 24'd0;
        end else if (tmo_q == TMO_MAX) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + 24'd1;
        end
    end

    // Frame assembly FSM: next state, shadow slots and output frame.
    always_comb begin
        state_d    = state_q;
        seen_d     = seen_q;
        sh_val_d   = sh_val_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        value_d    = value_q;
        dp_d       = dp_q;
        blank_d    = blank_q;
        valid_d    = 1'b0;
        stale_d    = stale_q;
        if (capture_s) begin
            sh_val_d[{idx_s, 2'b00} +: 4] = dec_s.nibble;
            sh_dp_d[idx_s]                = ~sample_s[7];
            sh_blank_d[idx_s]             = dec_s.blank;
            if (seen_next_s == 4'hF) begin
                value_d = sh_val_d;
                dp_d    = sh_dp_d;
                blank_d = sh_blank_d;
                valid_d = 1'b1;
                stale_d = 1'b0;
                seen_d  = 4'h0;
                state_d = ST_IDLE;
            end else begin
                seen_d  = seen_next_s;
                state_d = ST_COLLECT;
            end
        end else if ((state_q == ST_COLLECT) && (tmo_d == TMO_LIMIT)) begin
            seen_d  = 4'h0;
            stale_d = 1'b1;
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= {SCAN_W{1'b1}};
            cnt_q      <= 8'd0;
            tmo_q      <= 24'd0;
            state_q    <= ST_IDLE;
            seen_q     <= 4'h0;
            sh_val_q   <= 16'h0000;
            sh_dp_q    <= 4'h0;
            sh_blank_q <= 4'h0;
            value_q    <= 16'h0000;
            dp_q       <= 4'h0;
            blank_q    <= 4'h0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            prev_q     <= sample_s;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            state_q    <= state_d;
            seen_q     <= seen_d;
            sh_val_q   <= sh_val_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            value_q    <= value_d;
            dp_q       <= dp_d;
            blank_q    <= blank_d;
            valid_q    <= valid_d;
            illegal_q  <= illegal_d;
            stale_q    <= stale_d;
        end
    end

    assign value   = value_q;
    assign dp      = dp_q;
    assign blank   = blank_q;
    assign valid   = valid_q;
    assign illegal = illegal_q;
    assign stale   = stale_q;

endmodule
